aes_cipher_serializer: RTL and testbench

- Single-clock successor to the AES encryptor output buffer.
- Buffers whole cipher blocks (NO_ROWS x NO_COLS bytes) from the AES core in a DEPTH-entry block FIFO.
- Streams each block out over a valid/ready serial port of configurable width SER_W and bit order.
- Sits between the AES encryption core and the OFDM transmitter front end.
- Provides proper full/empty/level status, flush, and bubble-free back-to-back blocks.

---
 rtl/aes_opbuf_pkg.sv | 22 ++
 rtl/aes_opbuf_blk_fifo.sv | 67 ++++++
 rtl/aes_cipher_serializer.sv | 150 +++++++++++++++
 tb/tb_aes_cipher_serializer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_opbuf_pkg.sv
// ---------------------------------------------------------------------------
// aes_opbuf_pkg
// Shared types and helpers for the AES cipher-text serializer.
//   state_t        : serializer FSM states (S_IDLE, S_SEND)
//   blk_bits()     : bits in one cipher block of rows x cols bytes
//   BIT_ORDER_*    : encodings of the within-byte bit order parameter
// ---------------------------------------------------------------------------
package aes_opbuf_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   localparam int BIT_ORDER_LSB = 0;
   localparam int BIT_ORDER_MSB = 1;

   function automatic int blk_bits(input int rows, input int cols);
      return 8 * rows * cols;
   endfunction

endpackage

// File: rtl/aes_opbuf_blk_fifo.sv
// ---------------------------------------------------------------------------
// aes_opbuf_blk_fifo
// Block-wide FIFO holding whole cipher blocks between the AES core and the
// serializer. Pointers carry one extra wrap bit so full and empty are
// distinguishable without a separate counter.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_flush        synchronous clear (pointers equalised, push dropped)
//   i_push/i_wdata write one block (ignored when full)
//   i_pop          advance read pointer (ignored when empty)
//   o_rdata        head block (combinational read of current head)
//   o_level        blocks held, o_full / o_empty status
// ---------------------------------------------------------------------------
module aes_opbuf_blk_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 128
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [W-1:0]             i_wdata,
   input  logic                     i_pop,
   output logic [W-1:0]             o_rdata,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic [W-1:0] r_mem [DEPTH];

   logic w_do_push;
   logic w_do_pop;

   // No write bypass: a push into a full FIFO is refused even if a pop
   // frees an entry on the same edge.
   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= r_wr_ptr;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
   assign o_level = r_wr_ptr - r_rd_ptr;
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/aes_cipher_serializer.sv
// ---------------------------------------------------------------------------
// aes_cipher_serializer
// Buffers cipher blocks from the AES core in a DEPTH-block FIFO and streams
// each block to the OFDM front end as SER_W-bit beats, byte 0 first, bits
// within a byte in BIT_ORDER (first bit in ofdm_sdata[0]).
// Handshakes: a transfer happens on a rising edge where vld && rdy;
// cipher_txt_rdy depends only on full and flush, never on cipher_txt_vld.
// Ports:
//   aes_clk, reset            clock, asynchronous active-high reset
//   flush                     synchronous clear of FIFO and serializer
//   cipher_txt_vld/_rdy       block input handshake, aes_cipher_txt data
//   ofdm_sdata_vld/_rdy       serial beat handshake, ofdm_sdata data
//   level, full, empty        FIFO storage status (serializer excluded)
//   ofdm_sdata_last           final beat marker, only with AES_OPBUF_LAST_EN
// Optional feature macro: AES_OPBUF_LAST_EN
// ---------------------------------------------------------------------------
module aes_cipher_serializer
   import aes_opbuf_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int SER_W     = 1,
   parameter int NO_ROWS   = 4,
   parameter int NO_COLS   = 4,
   parameter int BIT_ORDER = 0
) (
   input  logic                     aes_clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     cipher_txt_vld,
   output logic                     cipher_txt_rdy,
   input  logic [7:0]               aes_cipher_txt [NO_ROWS][NO_COLS],
   output logic                     ofdm_sdata_vld,
   input  logic                     ofdm_sdata_rdy,
   output logic [SER_W-1:0]         ofdm_sdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
`ifdef AES_OPBUF_LAST_EN
   ,
   output logic                     ofdm_sdata_last
`endif
);

   localparam int BLK_BITS = blk_bits(NO_ROWS, NO_COLS);
   localparam int BEATS    = BLK_BITS / SER_W;
   localparam int CW       = $clog2(BEATS);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   logic [BLK_BITS-1:0] w_blk_flat;
   logic [BLK_BITS-1:0] w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_last_beat;

   state_t              r_state;
   logic [BLK_BITS-1:0] r_shift;
   logic [CW-1:0]       r_cnt;
   logic                r_vld;

   // Flatten byte k to bits [8k +: 8]. For MSB-first the bits of each byte
   // are mirrored here, so the serializer always shifts out from bit 0.
   for (genvar k = 0; k < NO_ROWS * NO_COLS; k++) begin : g_byte
      for (genvar b = 0; b < 8; b++) begin : g_bit
         if (BIT_ORDER == BIT_ORDER_MSB) begin : g_msb
            assign w_blk_flat[8*k + b] = aes_cipher_txt[k / NO_COLS][k % NO_COLS][7 - b];
         end else begin : g_lsb
            assign w_blk_flat[8*k + b] = aes_cipher_txt[k / NO_COLS][k % NO_COLS][b];
         end
      end
   end

   assign cipher_txt_rdy = !w_full && !flush;
   assign w_push         = cipher_txt_vld && cipher_txt_rdy;
   assign w_last_beat    = (r_cnt == LAST_BEAT);

   // Pop when idle with data waiting, or on the accepted final beat so the
   // next block follows without a bubble.
   assign w_pop = !flush && !w_empty &&
                  ((r_state == S_IDLE) ||
                   (ofdm_sdata_rdy && w_last_beat));

   aes_opbuf_blk_fifo #(
      .DEPTH (DEPTH),
      .W     (BLK_BITS)
   ) u_fifo (
      .i_clk   (aes_clk),
      .i_rst   (reset),
      .i_flush (flush),
      .i_push  (w_push),
      .i_wdata (w_blk_flat),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_level (level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge aes_clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_shift <= w_head;
                  r_cnt   <= '0;
                  r_vld   <= 1'b1;
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               // Data only moves on an accepted beat, so it is held stable
               // under backpressure.
               if (ofdm_sdata_rdy) begin
                  if (!w_last_beat) begin
                     r_shift <= r_shift >> SER_W;
                     r_cnt   <= r_cnt + CW'(1);
                  end else if (!w_empty) begin
                     r_shift <= w_head;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= '0;
                     r_vld   <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign ofdm_sdata_vld = r_vld;
   assign ofdm_sdata     = r_shift[SER_W-1:0];
   assign full           = w_full;
   assign empty          = w_empty;

`ifdef AES_OPBUF_LAST_EN
   assign ofdm_sdata_last = r_vld && w_last_beat;
`endif

endmodule

// File: tb/tb_aes_cipher_serializer.sv
// ---------------------------------------------------------------------------
// tb_aes_cipher_serializer
// Two instances share the block input and serial ready:
//   u_dut_a : SER_W=1, LSB first
//   u_dut_b : SER_W=4, MSB first
// A reference model expands every accepted block into its expected beat
// sequence from the byte/bit ordering rules and tracks how many blocks are
// in the system; valid, level, full, empty, ready and data are compared on
// every falling edge.
// ---------------------------------------------------------------------------
module tb_aes_cipher_serializer;

   localparam int DEPTH  = 8;
   localparam int SW_A   = 1;
   localparam int BO_A   = 0;
   localparam int SW_B   = 4;
   localparam int BO_B   = 1;

   // ---------------- clock / reset ----------------
   logic aes_clk;
   logic reset;
   initial aes_clk = 1'b0;
   always #5 aes_clk = ~aes_clk;

   // ---------------- stimulus signals ----------------
   logic       flush;
   logic       cvld;
   logic       ordy;
   logic [7:0] blk [4][4];

   logic       crdy_a, vld_a, full_a, empty_a;
   logic [0:0] dat_a;
   logic [3:0] lvl_a;
   logic       crdy_b, vld_b, full_b, empty_b;
   logic [3:0] dat_b;
   logic [3:0] lvl_b;
`ifdef AES_OPBUF_LAST_EN
   logic       last_a, last_b;
`endif

   aes_cipher_serializer #(
      .DEPTH(DEPTH), .SER_W(SW_A), .NO_ROWS(4), .NO_COLS(4), .BIT_ORDER(BO_A)
   ) u_dut_a (
      .aes_clk        (aes_clk),
      .reset          (reset),
      .flush          (flush),
      .cipher_txt_vld (cvld),
      .cipher_txt_rdy (crdy_a),
      .aes_cipher_txt (blk),
      .ofdm_sdata_vld (vld_a),
      .ofdm_sdata_rdy (ordy),
      .ofdm_sdata     (dat_a),
      .level          (lvl_a),
      .full           (full_a),
      .empty          (empty_a)
`ifdef AES_OPBUF_LAST_EN
      ,
      .ofdm_sdata_last(last_a)
`endif
   );

   aes_cipher_serializer #(
      .DEPTH(DEPTH), .SER_W(SW_B), .NO_ROWS(4), .NO_COLS(4), .BIT_ORDER(BO_B)
   ) u_dut_b (
      .aes_clk        (aes_clk),
      .reset          (reset),
      .flush          (flush),
      .cipher_txt_vld (cvld),
      .cipher_txt_rdy (crdy_b),
      .aes_cipher_txt (blk),
      .ofdm_sdata_vld (vld_b),
      .ofdm_sdata_rdy (ordy),
      .ofdm_sdata     (dat_b),
      .level          (lvl_b),
      .full           (full_b),
      .empty          (empty_b)
`ifdef AES_OPBUF_LAST_EN
      ,
      .ofdm_sdata_last(last_b)
`endif
   );

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q_a[$];
   logic [7:0] exp_q_b[$];
   int         prev_rem [2];
   int         beats_a, beats_b, acc_a, acc_b;
   int         n_tests, n_fail;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int q_size(input int id);
      return (id == 0) ? exp_q_a.size() : exp_q_b.size();
   endfunction

   function automatic logic [7:0] q_front(input int id);
      return (id == 0) ? exp_q_a[0] : exp_q_b[0];
   endfunction

   task automatic q_pop(input int id);
      if (id == 0) void'(exp_q_a.pop_front());
      else         void'(exp_q_b.pop_front());
   endtask

   task automatic q_push(input int id, input logic [7:0] v);
      if (id == 0) exp_q_a.push_back(v);
      else         exp_q_b.push_back(v);
   endtask

   task automatic q_clear(input int id);
      if (id == 0) exp_q_a.delete();
      else         exp_q_b.delete();
   endtask

   // Expand the current input block into beats: bytes 0..15 in order, each
   // byte's bits in the requested order, first bit of a beat in bit 0.
   task automatic push_block(input int id, input int sw, input int bo);
      logic [7:0] beat;
      logic [7:0] by;
      int         pos;
      beat = '0;
      pos  = 0;
      for (int k = 0; k < 16; k++) begin
         by = blk[k / 4][k % 4];
         for (int j = 0; j < 8; j++) begin
            beat[pos] = (bo == 1) ? by[7 - j] : by[j];
            pos++;
            if (pos == sw) begin
               q_push(id, beat);
               beat = '0;
               pos  = 0;
            end
         end
      end
   endtask

   // Per-cycle model step, called on the falling edge. prev_rem holds the
   // blocks that were present before the last edge and are still unfinished:
   // exactly those can be in the serializer, so they decide valid.
   task automatic mon_step(input int id, input int sw, input int bo,
                           input logic ovld, input logic [7:0] od, input logic ol,
                           input logic irdy, input logic [3:0] lvl,
                           input logic ful, input logic emp);
      int    beats, sz, nblk, lexp;
      logic  vexp;
      string p;
      p     = (id == 0) ? "a" : "b";
      beats = 128 / sw;
      sz    = q_size(id);
      nblk  = (sz + beats - 1) / beats;
      vexp  = (prev_rem[id] > 0);
      lexp  = nblk - (vexp ? 1 : 0);
      chk({p, "_vld"},   32'(ovld), 32'(vexp));
      chk({p, "_level"}, 32'(lvl),  32'(lexp));
      chk({p, "_full"},  32'(ful),  32'(lexp == DEPTH));
      chk({p, "_empty"}, 32'(emp),  32'(lexp == 0));
      chk({p, "_in_rdy"}, 32'(irdy), 32'((lexp != DEPTH) && !flush));
      if (ovld) begin
         if (sz == 0) chk({p, "_extra_beat"}, 32'd1, 32'd0);
         else begin
            chk({p, "_data"}, 32'(od), 32'(q_front(id)));
`ifdef AES_OPBUF_LAST_EN
            chk({p, "_last"}, 32'(ol), 32'((sz % beats) == 1));
`endif
         end
      end
      if (flush) begin
         q_clear(id);
         prev_rem[id] = 0;
      end else begin
         if (ovld && ordy && sz > 0) begin
            q_pop(id);
            if (id == 0) beats_a++;
            else         beats_b++;
         end
         prev_rem[id] = (q_size(id) + beats - 1) / beats;
         if (cvld && irdy) begin
            push_block(id, sw, bo);
            if (id == 0) acc_a++;
            else         acc_b++;
         end
      end
      if (bo > 1) chk("bad_order_param", 32'd0, 32'd1);
   endtask

   always @(negedge aes_clk) begin
      if (reset) begin
         q_clear(0);
         q_clear(1);
         prev_rem[0] = 0;
         prev_rem[1] = 0;
      end else begin
`ifdef AES_OPBUF_LAST_EN
         mon_step(0, SW_A, BO_A, vld_a, {7'd0, dat_a}, last_a, crdy_a, lvl_a, full_a, empty_a);
         mon_step(1, SW_B, BO_B, vld_b, {4'd0, dat_b}, last_b, crdy_b, lvl_b, full_b, empty_b);
`else
         mon_step(0, SW_A, BO_A, vld_a, {7'd0, dat_a}, 1'b0, crdy_a, lvl_a, full_a, empty_a);
         mon_step(1, SW_B, BO_B, vld_b, {4'd0, dat_b}, 1'b0, crdy_b, lvl_b, full_b, empty_b);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge aes_clk);
      #1;
   endtask

   task automatic rand_blk();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            blk[r][c] = 8'($urandom_range(0, 255));
   endtask

   task automatic a5_blk();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            blk[r][c] = 8'h00;
      blk[0][0] = 8'hA5;
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_a_vld"},   32'(vld_a),   32'd0);
      chk({tag, "_a_data"},  32'(dat_a),   32'd0);
      chk({tag, "_a_rdy"},   32'(crdy_a),  32'd1);
      chk({tag, "_a_level"}, 32'(lvl_a),   32'd0);
      chk({tag, "_a_full"},  32'(full_a),  32'd0);
      chk({tag, "_a_empty"}, 32'(empty_a), 32'd1);
      chk({tag, "_b_vld"},   32'(vld_b),   32'd0);
      chk({tag, "_b_data"},  32'(dat_b),   32'd0);
      chk({tag, "_b_level"}, 32'(lvl_b),   32'd0);
      chk({tag, "_b_empty"}, 32'(empty_b), 32'd1);
`ifdef AES_OPBUF_LAST_EN
      chk({tag, "_a_last"},  32'(last_a),  32'd0);
      chk({tag, "_b_last"},  32'(last_b),  32'd0);
`endif
   endtask

   task automatic wait_drain(input string tag, input int limit);
      int n;
      n = 0;
      while ((exp_q_a.size() != 0 || exp_q_b.size() != 0 || vld_a || vld_b) && n < limit) begin
         tick();
         n++;
      end
      chk({tag, "_drain_in_time"}, 32'(n < limit), 32'd1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      n_tests = 0; n_fail = 0;
      beats_a = 0; beats_b = 0; acc_a = 0; acc_b = 0;
      prev_rem[0] = 0; prev_rem[1] = 0;
      reset = 1'b1; flush = 1'b0; cvld = 1'b0; ordy = 1'b0;
      a5_blk();
      #1;
      rst_chk("por");
      repeat (2) tick();
      reset = 1'b0;
      tick();

      // Basic: one A5 block, full-rate sink.
      beats_a = 0; beats_b = 0;
      a5_blk();
      cvld = 1'b1;
      ordy = 1'b1;
      tick();
      cvld = 1'b0;
      wait_drain("basic", 400);
      chk("basic_beats_a", 32'(beats_a), 32'd128);
      chk("basic_beats_b", 32'(beats_b), 32'd32);
      chk("basic_empty_a", 32'(empty_a), 32'd1);

      // Backpressure: sink stalled, input valid held for 15 cycles.
      ordy = 1'b0;
      acc_a = 0; acc_b = 0;
      cvld = 1'b1;
      for (int i = 0; i < 15; i++) begin
         rand_blk();
         tick();
      end
      chk("bp_accepted_a", 32'(acc_a), 32'd9);
      chk("bp_accepted_b", 32'(acc_b), 32'd9);
      chk("bp_level_a",    32'(lvl_a), 32'd8);
      chk("bp_full_a",     32'(full_a), 32'd1);
      chk("bp_rdy_a",      32'(crdy_a), 32'd0);
      ordy = 1'b1;
      n = 0;
      while (acc_a < 10 && n < 300) begin
         tick();
         n++;
      end
      chk("bp_tenth_accepted", 32'(n >= 120 && n <= 140), 32'd1);
      cvld = 1'b0;
      wait_drain("bp", 3000);

      // Randomized traffic with stalls and occasional flush.
      for (int i = 0; i < 3000; i++) begin
         cvld  = 1'($urandom_range(0, 1));
         ordy  = ($urandom_range(0, 9) < 7);
         flush = ($urandom_range(0, 199) == 0);
         rand_blk();
         tick();
      end
      flush = 1'b0; cvld = 1'b0; ordy = 1'b1;
      wait_drain("rand", 3000);

      // Flush mid-block with three blocks stored.
      beats_a = 0;
      cvld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_blk();
         tick();
      end
      cvld = 1'b0;
      n = 0;
      while (beats_a < 40 && n < 200) begin
         tick();
         n++;
      end
      chk("fl_reach_beat40", 32'(n < 200), 32'd1);
      chk("fl_level_before", 32'(lvl_a), 32'd3);
      flush = 1'b1;
      cvld  = 1'b1;
      rand_blk();
      tick();
      flush = 1'b0;
      cvld  = 1'b0;
      @(negedge aes_clk);
      chk("fl_vld_a",   32'(vld_a),   32'd0);
      chk("fl_level_a", 32'(lvl_a),   32'd0);
      chk("fl_empty_a", 32'(empty_a), 32'd1);
      chk("fl_level_b", 32'(lvl_b),   32'd0);
      repeat (20) tick();
      chk("fl_no_beats", 32'(vld_a || vld_b), 32'd0);

      // Asynchronous reset during beat 10 of a block.
      beats_a = 0;
      rand_blk();
      cvld = 1'b1;
      tick();
      cvld = 1'b0;
      n = 0;
      while (beats_a < 10 && n < 100) begin
         tick();
         n++;
      end
      @(posedge aes_clk);
      #2;
      reset = 1'b1;
      #1;
      rst_chk("mid_rst");
      repeat (2) tick();
      reset = 1'b0;
      tick();
      beats_a = 0; beats_b = 0;
      a5_blk();
      cvld = 1'b1;
      tick();
      cvld = 1'b0;
      wait_drain("post_rst", 400);
      chk("post_rst_beats_a", 32'(beats_a), 32'd128);
      chk("post_rst_beats_b", 32'(beats_b), 32'd32);

      chk("final_q_a", 32'(exp_q_a.size()), 32'd0);
      chk("final_q_b", 32'(exp_q_b.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
